// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable generator running on the PLL clock.
// Produces single-cycle clk_en_o pulses in HALT / STEP / RUN_DIV / RUN_FULL
// modes, with a synchronised and debounced step button, a runtime period,
// CPU-halt gating and a wrapping pulse counter.
module cpu_clock_ctrl #(
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned DB_WIDTH        = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode_i,
  input  logic                 step_btn_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 cpu_halt_i,
  output logic                 clk_en_o,
  output logic                 running_o,
  output logic                 btn_db_o,
  output logic [CNT_WIDTH-1:0] step_count_o
);

  typedef enum logic [1:0] {
    MODE_HALT     = 2'b00,
    MODE_STEP     = 2'b01,
    MODE_RUN_DIV  = 2'b10,
    MODE_RUN_FULL = 2'b11
  } mode_t;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  mode_t                mode;
  mode_t                mode_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 btn_sync;
  logic [DB_WIDTH-1:0]  db_cnt_q, db_cnt_d;
  logic                 btn_db_d;
  logic                 step_req_q, step_req_d;
  logic [DIV_WIDTH-1:0] period;
  logic [DIV_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic                 clk_en_d;

  assign mode     = mode_t'(mode_i);
  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign period   = (div_i == '0) ? DIV_WIDTH'(1) : div_i;

  // Button synchroniser chain: the only logic that sees step_btn_i
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], step_btn_i};
  end

  // Debounce: count mismatching cycles, toggle the level after a full run,
  // and raise a one-cycle step request only on a rising toggle
  always_comb begin
    db_cnt_d   = '0;
    btn_db_d   = btn_db_o;
    step_req_d = 1'b0;
    if (btn_sync != btn_db_o) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d   = ~btn_db_o;
        step_req_d = ~btn_db_o;
      end else begin
        db_cnt_d = db_cnt_q + DB_WIDTH'(1);
      end
    end
  end

  // Pulse decision from current-cycle mode, period and halt flag
  always_comb begin
    clk_en_d  = 1'b0;
    per_cnt_d = '0;
    if (!cpu_halt_i) begin
      case (mode)
        MODE_STEP:     clk_en_d = step_req_q;
        MODE_RUN_FULL: clk_en_d = 1'b1;
        MODE_RUN_DIV: begin
          // >= rather than == so a shrinking div_i wraps immediately
          if (mode == mode_q) begin
            if (per_cnt_q >= period - DIV_WIDTH'(1)) clk_en_d  = 1'b1;
            else                                     per_cnt_d = per_cnt_q + DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered mode copy for change detection; it follows mode_i even during
  // reset so the first post-reset RUN_DIV period is not restarted a second time
  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q     <= '0;
      btn_db_o     <= 1'b0;
      step_req_q   <= 1'b0;
      per_cnt_q    <= '0;
      clk_en_o     <= 1'b0;
      running_o    <= 1'b0;
      step_count_o <= '0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      btn_db_o     <= btn_db_d;
      step_req_q   <= step_req_d;
      per_cnt_q    <= per_cnt_d;
      clk_en_o     <= clk_en_d;
      running_o    <= mode_i[1] & ~cpu_halt_i;
      step_count_o <= step_count_o + CNT_WIDTH'(clk_en_o);
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed bench with a cycle-level reference model.
module tb_cpu_clock_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        btn;
  logic [23:0] div;
  logic        halt;
  logic        clk_en_o;
  logic        running_o;
  logic        btn_db_o;
  logic [3:0]  step_count_o;

  int total = 0;
  int bad   = 0;

  cpu_clock_ctrl #(
    .DIV_WIDTH(24),
    .DEBOUNCE_CYCLES(DEB),
    .DB_WIDTH(18),
    .SYNC_STAGES(2),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_i(mode),
    .step_btn_i(btn),
    .div_i(div),
    .cpu_halt_i(halt),
    .clk_en_o(clk_en_o),
    .running_o(running_o),
    .btn_db_o(btn_db_o),
    .step_count_o(step_count_o)
  );

  always #5 clk = ~clk;

  // Reference model: edge timestamps for the period, a sample queue for the
  // synchroniser, a mismatch run length for debounce, integer pulse count.
  int unsigned m_edge = 0;
  int unsigned m_mark = 0;
  logic [1:0]  m_prev_mode = 2'b00;
  bit          m_hist[$] = '{1'b0, 1'b0};
  int          m_mis = 0;
  bit          m_db = 1'b0;
  bit          m_rose = 1'b0;
  bit          m_en = 1'b0;
  bit          m_run = 1'b0;
  int          m_count = 0;

  always @(posedge clk) begin
    bit synced;
    bit pend;
    int p;
    m_edge++;
    if (!rst_n) begin
      m_hist      = '{1'b0, 1'b0};
      m_mis       = 0;
      m_db        = 1'b0;
      m_rose      = 1'b0;
      m_en        = 1'b0;
      m_run       = 1'b0;
      m_count     = 0;
      m_mark      = m_edge;
      m_prev_mode = mode;
    end else begin
      m_count = (m_count + (m_en ? 1 : 0)) % 16;
      synced = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(btn);
      pend   = m_rose;
      m_rose = 1'b0;
      if (synced != m_db) begin
        m_mis++;
        if (m_mis == DEB) begin
          m_db   = !m_db;
          m_mis  = 0;
          m_rose = m_db;
        end
      end else begin
        m_mis = 0;
      end
      p = (div == 0) ? 1 : int'(div);
      if (halt) m_en = 1'b0;
      else begin
        case (mode)
          2'b00: m_en = 1'b0;
          2'b01: m_en = pend;
          2'b11: m_en = 1'b1;
          default: begin
            if (mode != m_prev_mode) m_en = 1'b0;
            else if (int'(m_edge - m_mark) >= p) begin
              m_en   = 1'b1;
              m_mark = m_edge;
            end else m_en = 1'b0;
          end
        endcase
      end
      if (halt || mode != 2'b10 || mode != m_prev_mode) m_mark = m_edge;
      m_run       = mode[1] & ~halt;
      m_prev_mode = mode;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample on the falling edge and compare against the model
  task automatic tick();
    @(negedge clk);
    check("model_clk_en",  32'(clk_en_o),     32'(m_en));
    check("model_running", 32'(running_o),    32'(m_run));
    check("model_btn_db",  32'(btn_db_o),     32'(m_db));
    check("model_count",   32'(step_count_o), 32'(m_count));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; mode = 2'b11; btn = 1'b0; div = 24'd0; halt = 1'b0;

    // 1. reset under RUN_FULL, then free running with counter wrap
    tick(); tick();
    check("rst_clk_en", 32'(clk_en_o), 32'd0);
    check("rst_running", 32'(running_o), 32'd0);
    check("rst_btn_db", 32'(btn_db_o), 32'd0);
    check("rst_count", 32'(step_count_o), 32'd0);
    rst_n = 1'b1;
    tick();
    check("full_first_edge", 32'(clk_en_o), 32'd1);
    check("full_running", 32'(running_o), 32'd1);
    repeat (15) tick();
    check("count_at_15", 32'(step_count_o), 32'd15);
    tick();
    check("count_wrap", 32'(step_count_o), 32'd0);

    // 2. STEP: debounced press gives exactly one pulse; glitch gives none
    mode = 2'b01;
    tick(); tick();
    btn = 1'b1;
    repeat (5) tick();
    check("db_not_yet", 32'(btn_db_o), 32'd0);
    tick();
    check("db_rise_6", 32'(btn_db_o), 32'd1);
    check("no_pulse_at_rise", 32'(clk_en_o), 32'd0);
    tick();
    check("step_pulse", 32'(clk_en_o), 32'd1);
    tick();
    check("step_single", 32'(clk_en_o), 32'd0);
    tick(); tick();
    btn = 1'b0;
    pulses = 0;
    repeat (10) begin tick(); pulses += int'(clk_en_o); end
    check("release_db_low", 32'(btn_db_o), 32'd0);
    check("release_no_pulse", 32'(pulses), 32'd0);
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    pulses = 0;
    repeat (10) begin tick(); pulses += int'(clk_en_o); end
    check("glitch_db", 32'(btn_db_o), 32'd0);
    check("glitch_no_pulse", 32'(pulses), 32'd0);

    // 3. RUN_DIV period 5, then div 0 and 1
    mode = 2'b10; div = 24'd5;
    for (int t = 1; t <= 15; t++) begin
      tick();
      check("div5_pattern", 32'(clk_en_o), 32'((t == 6 || t == 11) ? 1 : 0));
    end
    div = 24'd0;
    repeat (5) begin tick(); check("div0_every", 32'(clk_en_o), 32'd1); end
    div = 24'd1;
    repeat (5) begin tick(); check("div1_every", 32'(clk_en_o), 32'd1); end

    // 4. shrink div from 10 to 3 with counter at 7
    div = 24'd10;
    repeat (7) begin tick(); check("div10_quiet", 32'(clk_en_o), 32'd0); end
    div = 24'd3;
    for (int t = 1; t <= 9; t++) begin
      tick();
      check("shrink_pattern", 32'(clk_en_o), 32'((t == 1 || t == 4 || t == 7) ? 1 : 0));
    end

    // 5. CPU halt gating, step press while halted is dropped
    mode = 2'b11; halt = 1'b1;
    repeat (3) tick();
    check("halt_full_en", 32'(clk_en_o), 32'd0);
    check("halt_running", 32'(running_o), 32'd0);
    mode = 2'b01; btn = 1'b1;
    pulses = 0;
    repeat (12) begin tick(); pulses += int'(clk_en_o); end
    halt = 1'b0;
    repeat (10) begin tick(); pulses += int'(clk_en_o); end
    check("halt_db_high", 32'(btn_db_o), 32'd1);
    check("halt_step_dropped", 32'(pulses), 32'd0);
    btn = 1'b0;
    pulses = 0;
    repeat (8) begin tick(); pulses += int'(clk_en_o); end
    check("halt_release_quiet", 32'(pulses), 32'd0);

    // 6. reset mid period and mid debounce
    mode = 2'b10; div = 24'd5;
    repeat (3) tick();
    btn = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0; btn = 1'b0;
    tick();
    check("midrst_en", 32'(clk_en_o), 32'd0);
    check("midrst_db", 32'(btn_db_o), 32'd0);
    check("midrst_count", 32'(step_count_o), 32'd0);
    check("midrst_running", 32'(running_o), 32'd0);
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check("post_rst_pattern", 32'(clk_en_o), 32'((t == 5 || t == 10) ? 1 : 0));
    end
    check("post_rst_db", 32'(btn_db_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
